seq_pattern_detector: RTL and testbench
=======================================

SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

Interface
REQ-001 Parameter: PAT_W, 3, pattern length in bits; legal range 2..16.
REQ-002 Parameter: CNT_W, 8, match counter width; legal range 1..32.
REQ-003 Parameter: RST_PATTERN, 3'b101 zero-extended to PAT_W, pattern held after reset.
REQ-004 Port: clk  input  1  single clock; all logic on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: in_valid  input  1  serial_in is sampled only when high.
REQ-007 Port: serial_in  input  1  serial data bit; newest bit enters window LSB.
REQ-008 Port: cfg_load  input  1  loads pattern_cfg into the pattern register.
REQ-009 Port: pattern_cfg  input  PAT_W  new target pattern, MSB = oldest bit.
REQ-010 Port: overlap_en  input  1  1 = overlapping matches, 0 = non-overlapping.
REQ-011 Port: window  output  PAT_W  current shift window.
REQ-012 Port: pattern_detected  output  1  one-cycle match pulse.
REQ-013 Port: match_count  output  CNT_W  saturating match count (see Configuration).

Function
REQ-014 Beat: a cycle with in_valid=1; non-beat cycles hold window, fill count and FSM.
REQ-015 On a beat, window SHALL become {window[PAT_W-2:0], serial_in}.
REQ-016 FSM states: FILL (fewer than PAT_W bits since last clear), ARMED (window holds PAT_W valid bits).
REQ-017 FILL: 0..PAT_W-1 bit counter increments per beat; the beat delivering bit PAT_W moves FSM to ARMED.
REQ-018 Match: a beat where the next window equals the pattern register and the FSM is ARMED or completes FILL on that beat.
REQ-019 pattern_detected SHALL be registered: high for exactly the cycle after the matching beat, low otherwise.
REQ-020 overlap_en=1: after a match FSM stays ARMED; window retained (101 in 10101 gives 2 matches).
REQ-021 overlap_en=0: after a match window clears to 0, FSM returns to FILL with count 0 (10101 gives 1 match).
REQ-022 overlap_en sampled on the matching beat only; changes between matches take effect at the next match.
REQ-023 cfg_load=1: pattern register <= pattern_cfg; window cleared; FSM to FILL; any beat in that cycle discarded; no match pulse next cycle.
REQ-024 cfg_load has priority over in_valid; reset has priority over both.
REQ-025 No match is possible before PAT_W beats (including leading zeros matching a zero pattern).

Reset
REQ-026 On reset=1 at a clock edge: window=0, pattern_detected=0, match_count=0, FSM=FILL, fill count=0, pattern register=RST_PATTERN.
REQ-027 Reset asserted mid-FILL or mid-match SHALL discard partial state; a pending match pulse SHALL not appear.
REQ-028 Outputs SHALL be valid from the first cycle after reset deasserts; no asynchronous path from reset.

Configuration
REQ-029 Macro PATDET_MATCH_COUNT_EN defined: match_count increments by 1 per match pulse, saturates at 2^CNT_W-1, clears on reset and cfg_load.
REQ-030 Macro PATDET_MATCH_COUNT_EN undefined: match_count tied to 0, counter logic absent; all other behaviour identical.

Verification
REQ-031 PAT_W=3, reset, overlap_en=1, beats 1,0,1,0,1 -> pattern_detected high the cycle after beat 3 and after beat 5; match_count=2.
REQ-032 Same stream, overlap_en=0 -> single pulse after beat 3, none after beat 5; window=3'b001 after beat 5; match_count=1.
REQ-033 Pattern 101, beats 1,0 then in_valid=0 for 4 cycles, then beat 1 -> no pulse during gap; pulse the cycle after the final beat.
REQ-034 cfg_load with pattern_cfg=3'b000, then beats 0,0 -> no pulse; third 0 beat -> pulse; cfg_load same cycle as a beat -> beat ignored, window=0.
REQ-035 CNT_W=2, count enabled, overlap_en=1, stream 1 followed by 0,1 repeated 5 times -> 5 pulses; match_count saturates at 3.
REQ-036 Reset asserted on the cycle of a matching beat -> no pulse next cycle; window=0, match_count=0, pattern=101.

Source files
------------

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - serial bit-pattern detector with overlap control and match pulse
// Optional saturating match counter is built only when PATDET_MATCH_COUNT_EN is defined.
module seq_pattern_detector #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8,
  parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(3'b101)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             serial_in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pattern_cfg,
  input  logic             overlap_en,
  output logic [PAT_W-1:0] window,
  output logic             pattern_detected,
  output logic [CNT_W-1:0] match_count
);

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] window_q, window_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [4:0]       fill_q, fill_d;
  logic             det_q, det_d;
  logic [PAT_W-1:0] shifted;
  logic             fill_done;
  logic             match;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FILL;
      window_q  <= '0;
      pattern_q <= RST_PATTERN;
      fill_q    <= '0;
      det_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      window_q  <= window_d;
      pattern_q <= pattern_d;
      fill_q    <= fill_d;
      det_q     <= det_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    window_d  = window_q;
    pattern_d = pattern_q;
    fill_d    = fill_q;
    det_d     = 1'b0;
    match     = 1'b0;
    shifted   = {window_q[PAT_W-2:0], serial_in};
    fill_done = (state_q == FILL) && (fill_q == 5'(PAT_W - 1));

    if (cfg_load) begin
      // A beat coinciding with a reconfiguration is dropped on purpose.
      pattern_d = pattern_cfg;
      window_d  = '0;
      state_d   = FILL;
      fill_d    = '0;
    end else if (in_valid) begin
      window_d = shifted;
      if (fill_done) begin
        state_d = ARMED;
        fill_d  = '0;
      end else if (state_q == FILL) begin
        fill_d = fill_q + 5'd1;
      end
      match = ((state_q == ARMED) || fill_done) && (shifted == pattern_q);
      if (match) begin
        det_d = 1'b1;
        if (!overlap_en) begin
          window_d = '0;
          state_d  = FILL;
          fill_d   = '0;
        end
      end
    end
  end

  assign window           = window_q;
  assign pattern_detected = det_q;

`ifdef PATDET_MATCH_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (cfg_load) begin
      count_d = '0;
    end else if (match && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign match_count = count_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - directed self-checking bench for seq_pattern_detector
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       serial_in;
  logic       cfg_load;
  logic [2:0] pattern_cfg;
  logic       overlap_en;
  logic [2:0] window;
  logic       pattern_detected;
  logic [1:0] match_count;

  int checks = 0;
  int errors = 0;

`ifdef PATDET_MATCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  seq_pattern_detector #(.PAT_W(3), .CNT_W(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .serial_in        (serial_in),
    .cfg_load         (cfg_load),
    .pattern_cfg      (pattern_cfg),
    .overlap_en       (overlap_en),
    .window           (window),
    .pattern_detected (pattern_detected),
    .match_count      (match_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cexp(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
  endtask

  task automatic beat(input logic b);
    in_valid  = 1'b1;
    serial_in = b;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    serial_in   = 1'b0;
    cfg_load    = 1'b0;
    pattern_cfg = 3'b000;
    overlap_en  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_window", window, 3'b000);
    check("rst_det", pattern_detected, 1'b0);
    check("rst_count", match_count, 2'd0);

    // overlapping 10101
    overlap_en = 1'b1;
    beat(1'b1); check("ov_b1_det", pattern_detected, 1'b0);
    beat(1'b0); check("ov_b2_det", pattern_detected, 1'b0);
    beat(1'b1); check("ov_b3_det", pattern_detected, 1'b1);
    check("ov_b3_win", window, 3'b101);
    beat(1'b0); check("ov_b4_det", pattern_detected, 1'b0);
    beat(1'b1); check("ov_b5_det", pattern_detected, 1'b1);
    check("ov_count", match_count, cexp(2));
    tick(); check("ov_idle_det", pattern_detected, 1'b0);

    // non-overlapping 10101
    do_reset();
    overlap_en = 1'b0;
    beat(1'b1); check("no_b1_det", pattern_detected, 1'b0);
    beat(1'b0); check("no_b2_det", pattern_detected, 1'b0);
    beat(1'b1); check("no_b3_det", pattern_detected, 1'b1);
    check("no_b3_win", window, 3'b000);
    beat(1'b0); check("no_b4_det", pattern_detected, 1'b0);
    beat(1'b1); check("no_b5_det", pattern_detected, 1'b0);
    check("no_b5_win", window, 3'b001);
    check("no_count", match_count, cexp(1));

    // gap in in_valid holds state
    do_reset();
    overlap_en = 1'b1;
    beat(1'b1);
    beat(1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("gap_det", pattern_detected, 1'b0);
      check("gap_win", window, 3'b010);
    end
    beat(1'b1); check("gap_final_det", pattern_detected, 1'b1);

    // zero pattern via cfg_load, fill guard, and cfg_load beating a beat
    pattern_cfg = 3'b000;
    cfg_load    = 1'b1;
    tick();
    check("cfg_det", pattern_detected, 1'b0);
    check("cfg_win", window, 3'b000);
    check("cfg_count", match_count, 2'd0);
    beat(1'b0); check("z_b1_det", pattern_detected, 1'b0);
    beat(1'b0); check("z_b2_det", pattern_detected, 1'b0);
    beat(1'b0); check("z_b3_det", pattern_detected, 1'b1);
    beat(1'b1); check("z_b4_win", window, 3'b001);
    cfg_load  = 1'b1;
    in_valid  = 1'b1;
    serial_in = 1'b1;
    tick();
    check("cfgbeat_win", window, 3'b000);
    check("cfgbeat_det", pattern_detected, 1'b0);
    check("cfgbeat_count", match_count, 2'd0);

    // saturation with CNT_W=2: 1 then (0,1) x5
    do_reset();
    overlap_en = 1'b1;
    beat(1'b1);
    for (int k = 1; k <= 5; k++) begin
      beat(1'b0); check("sat_zero_det", pattern_detected, 1'b0);
      beat(1'b1); check("sat_one_det", pattern_detected, 1'b1);
      check("sat_count", match_count, cexp(k > 3 ? 3 : k));
    end

    // reset on a matching beat
    do_reset();
    beat(1'b1);
    beat(1'b0);
    reset     = 1'b1;
    in_valid  = 1'b1;
    serial_in = 1'b1;
    tick();
    reset = 1'b0;
    check("rstm_det", pattern_detected, 1'b0);
    check("rstm_win", window, 3'b000);
    check("rstm_count", match_count, 2'd0);
    beat(1'b1); check("rstm_b1_det", pattern_detected, 1'b0);
    beat(1'b0); check("rstm_b2_det", pattern_detected, 1'b0);
    beat(1'b1); check("rstm_b3_det", pattern_detected, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
